// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Lets the IF stage (instruction fetch) and the MEM stage (load/store) share one
// single-port synchronous RAM (8-bit address, 16-bit data, 1-cycle read latency).
// At most one access is granted each cycle. The losing stage is stalled. Returned
// read data goes back to the stage that issued the access.
//
// Configuration macro: ROUND_ROBIN_EN
//   undefined : D wins a conflict unless IF has already lost MAX_WAIT times in a row.
//   defined   : a conflict goes to the opposite of the last conflict winner.
//
// Parameter:
//   MAX_WAIT      consecutive IF denials after which IF beats D (1..15)
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   i_req/i_addr  IF fetch request and address
//   i_stall       IF is requesting but was not granted this cycle
//   i_valid       i_rdata carries fetched data (cycle after IF grant)
//   i_rdata       fetched instruction, holds the last value while i_valid=0
//   d_req/d_we/d_addr/d_wdata  MEM stage access request (d_we=1 store)
//   d_stall       D is requesting but was not granted this cycle
//   d_valid       D access complete (cycle after D grant)
//   d_rdata       load data, holds the last load value otherwise
//   m_en/m_we/m_addr/m_wdata   RAM command, combinational from the grant
//   m_rdata       RAM read data, one cycle after a read command
//   conflict_cnt  saturating count of cycles with both stages requesting
module mem_port_arbiter #(
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [7:0]  i_addr,
   output logic        i_stall,
   output logic        i_valid,
   output logic [15:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [7:0]  d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_stall,
   output logic        d_valid,
   output logic [15:0] d_rdata,
   output logic        m_en,
   output logic        m_we,
   output logic [7:0]  m_addr,
   output logic [15:0] m_wdata,
   input  logic [15:0] m_rdata,
   output logic [15:0] conflict_cnt
);

   // The owner state records which access was issued last cycle. The response
   // to that access is present this cycle.
   typedef enum logic [1:0] {
      IDLE,
      RD_I,
      RD_D,
      WR_D
   } ownerState_e;

   ownerState_e ownerState_q, ownerState_d;
   logic [3:0]  waitCnt_q, waitCnt_d;
   logic [15:0] conflictCnt_q, conflictCnt_d;
   logic [15:0] iRdata_q, dRdata_q;
   logic        grantI, grantD;
   logic        bothReq;

`ifdef ROUND_ROBIN_EN
   // Set when D won the most recent conflict. The reset value is D, so the
   // first conflict goes to IF.
   logic        lastGrantD_q, lastGrantD_d;
`endif

   assign bothReq = i_req & d_req;

   // Grant selection. No grant is given while reset is held.
   always_comb begin
      grantI = 1'b0;
      grantD = 1'b0;
      if (!reset) begin
         if (bothReq) begin
`ifdef ROUND_ROBIN_EN
            if (lastGrantD_q) grantI = 1'b1;
            else              grantD = 1'b1;
`else
            // The starvation guard gives IF the port once it has waited long enough.
            if (waitCnt_q >= 4'(MAX_WAIT)) grantI = 1'b1;
            else                           grantD = 1'b1;
`endif
         end else if (i_req) begin
            grantI = 1'b1;
         end else if (d_req) begin
            grantD = 1'b1;
         end
      end
   end

   assign i_stall = i_req & ~grantI;
   assign d_stall = d_req & ~grantD;

   // Build the RAM command from the grant. When nothing is granted, every RAM input is driven to zero.
   always_comb begin
      m_en    = 1'b0;
      m_we    = 1'b0;
      m_addr  = 8'h00;
      m_wdata = 16'h0000;
      if (grantI) begin
         m_en   = 1'b1;
         m_addr = i_addr;
      end else if (grantD) begin
         m_en    = 1'b1;
         m_we    = d_we;
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end
   end

   // Next owner state and counter updates. The owner state follows the grant
   // made this cycle, so a new access can overlap the response to the previous one.
   always_comb begin
      ownerState_d  = IDLE;
      waitCnt_d     = waitCnt_q;
      conflictCnt_d = conflictCnt_q;
`ifdef ROUND_ROBIN_EN
      lastGrantD_d  = lastGrantD_q;
`endif

      if (grantI)            ownerState_d = RD_I;
      else if (grantD && d_we) ownerState_d = WR_D;
      else if (grantD)       ownerState_d = RD_D;

      if (!i_req || grantI)      waitCnt_d = 4'd0;
      else if (waitCnt_q != 4'hF) waitCnt_d = waitCnt_q + 4'd1;

      if (bothReq && (conflictCnt_q != 16'hFFFF))
         conflictCnt_d = conflictCnt_q + 16'd1;

`ifdef ROUND_ROBIN_EN
      if (bothReq) lastGrantD_d = grantD;
`endif
   end

   // State registers. The read-data copies capture the RAM output whenever a
   // read response returns, so the value is still available after valid drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         ownerState_q  <= IDLE;
         waitCnt_q     <= 4'd0;
         conflictCnt_q <= 16'd0;
         iRdata_q      <= 16'd0;
         dRdata_q      <= 16'd0;
`ifdef ROUND_ROBIN_EN
         lastGrantD_q  <= 1'b1;
`endif
      end else begin
         ownerState_q  <= ownerState_d;
         waitCnt_q     <= waitCnt_d;
         conflictCnt_q <= conflictCnt_d;
         if (ownerState_q == RD_I) iRdata_q <= m_rdata;
         if (ownerState_q == RD_D) dRdata_q <= m_rdata;
`ifdef ROUND_ROBIN_EN
         lastGrantD_q  <= lastGrantD_d;
`endif
      end
   end

   // Responses are gated by reset, so a read still in flight when reset
   // arrives never shows up as valid data.
   always_comb begin
      i_valid = 1'b0;
      d_valid = 1'b0;
      i_rdata = 16'd0;
      d_rdata = 16'd0;
      if (!reset) begin
         i_valid = (ownerState_q == RD_I);
         d_valid = (ownerState_q == RD_D) || (ownerState_q == WR_D);
         i_rdata = (ownerState_q == RD_I) ? m_rdata : iRdata_q;
         d_rdata = (ownerState_q == RD_D) ? m_rdata : dRdata_q;
      end
   end

   assign conflict_cnt = conflictCnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. It includes a behavioural RAM with preset
// contents. Expected read data is queued when an access is issued. A separate
// monitor pops and compares the data whenever the DUT asserts i_valid or d_valid.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [7:0]  i_addr;
   logic        i_stall;
   logic        i_valid;
   logic [15:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [7:0]  d_addr;
   logic [15:0] d_wdata;
   logic        d_stall;
   logic        d_valid;
   logic [15:0] d_rdata;
   logic        m_en;
   logic        m_we;
   logic [7:0]  m_addr;
   logic [15:0] m_wdata;
   logic [15:0] m_rdata;
   logic [15:0] conflict_cnt;

   int          errors = 0;
   int          checks = 0;
   bit          monOn  = 1'b1;

   logic [15:0] iExpQ[$];
   logic [15:0] dExpQ[$];

   logic [15:0] ramMem [256];
   bit          ramWritten [256];

   mem_port_arbiter #(.MAX_WAIT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_req        (i_req),
      .i_addr       (i_addr),
      .i_stall      (i_stall),
      .i_valid      (i_valid),
      .i_rdata      (i_rdata),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_stall      (d_stall),
      .d_valid      (d_valid),
      .d_rdata      (d_rdata),
      .m_en         (m_en),
      .m_we         (m_we),
      .m_addr       (m_addr),
      .m_wdata      (m_wdata),
      .m_rdata      (m_rdata),
      .conflict_cnt (conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Preset RAM contents used by the directed tests.
   function automatic logic [15:0] presetVal(input logic [7:0] a);
      if (a >= 8'h10 && a <= 8'h14) return 16'h1234 + 16'(a - 8'h10);
      if (a == 8'h20) return 16'h2020;
      if (a == 8'h30) return 16'h3030;
      return 16'h0000;
   endfunction

   // Single-port synchronous RAM with a one-cycle read latency.
   always @(posedge clk) begin
      if (m_en) begin
         if (m_we) begin
            ramMem[m_addr]     <= m_wdata;
            ramWritten[m_addr] <= 1'b1;
         end else begin
            m_rdata <= ramWritten[m_addr] ? ramMem[m_addr] : presetVal(m_addr);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic ir, input logic [7:0] ia, input logic dr,
                                input logic dw, input logic [7:0] da, input logic [15:0] dd);
      i_req   = ir;
      i_addr  = ia;
      d_req   = dr;
      d_we    = dw;
      d_addr  = da;
      d_wdata = dd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Response monitor: checks returned data against the scoreboard queues.
   initial begin
      forever begin
         @(negedge clk);
         if (monOn) begin
            if (i_valid) begin
               checks++;
               if (iExpQ.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL i_valid_unexpected: got i_valid=1 required no response at %0t", $time);
               end else begin
                  checks--;
                  checkOutput("i_rdata", 32'(i_rdata), 32'(iExpQ.pop_front()));
               end
            end
            if (d_valid) begin
               checks++;
               if (dExpQ.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL d_valid_unexpected: got d_valid=1 required no response at %0t", $time);
               end else begin
                  checks--;
                  checkOutput("d_rdata", 32'(d_rdata), 32'(dExpQ.pop_front()));
               end
            end
         end
      end
   end

   // Watchdog in case the run stalls.
   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit expI;
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      step();
      step();

      // Reset state
      @(negedge clk);
      checkOutput("rst_i_valid", 32'(i_valid), 0);
      checkOutput("rst_d_valid", 32'(d_valid), 0);
      checkOutput("rst_i_rdata", 32'(i_rdata), 0);
      checkOutput("rst_d_rdata", 32'(d_rdata), 0);
      checkOutput("rst_m_en", 32'(m_en), 0);
      checkOutput("rst_conflict_cnt", 32'(conflict_cnt), 0);
      step();
      reset = 1'b0;

      // Test 1: stream of five IF fetches, back to back
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1, 8'h10 + 8'(k), 0, 0, 0, 0);
         iExpQ.push_back(16'h1234 + 16'(k));
         @(negedge clk);
         checkOutput("t1_i_stall", 32'(i_stall), 0);
         checkOutput("t1_m_en", 32'(m_en), 1);
         checkOutput("t1_m_we", 32'(m_we), 0);
         checkOutput("t1_m_addr", 32'(m_addr), 32'(8'h10 + 8'(k)));
         if (k > 0) checkOutput("t1_i_valid_stream", 32'(i_valid), 1);
         step();
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t1_i_valid_last", 32'(i_valid), 1);
      checkOutput("t1_m_en_idle", 32'(m_en), 0);
      step();
      @(negedge clk);
      checkOutput("t1_i_valid_drop", 32'(i_valid), 0);
      checkOutput("t1_i_rdata_hold", 32'(i_rdata), 32'h1238);
      step();

      // Test 2: both stages requesting for six cycles (round robin in the alternate build)
      applyStimulus(1, 8'h30, 1, 0, 8'h20, 0);
      for (int c = 1; c <= 6; c++) begin
`ifdef ROUND_ROBIN_EN
         expI = (c % 2) == 1;
`else
         expI = (c == 5);
`endif
         if (expI) iExpQ.push_back(16'h3030);
         else      dExpQ.push_back(16'h2020);
         @(negedge clk);
         checkOutput("t2_i_stall", 32'(i_stall), 32'(!expI));
         checkOutput("t2_d_stall", 32'(d_stall), 32'(expI));
         checkOutput("t2_m_addr", 32'(m_addr), expI ? 32'h30 : 32'h20);
         checkOutput("t2_conflict_cnt", 32'(conflict_cnt), 32'(c - 1));
         step();
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t2_conflict_cnt_final", 32'(conflict_cnt), 6);
      step();

      // Test 3: store, then load back from the same address
      applyStimulus(0, 0, 1, 1, 8'h05, 16'hBEEF);
      dExpQ.push_back(16'h2020);
      @(negedge clk);
      checkOutput("t3_m_en", 32'(m_en), 1);
      checkOutput("t3_m_we", 32'(m_we), 1);
      checkOutput("t3_m_addr", 32'(m_addr), 32'h05);
      checkOutput("t3_m_wdata", 32'(m_wdata), 32'hBEEF);
      checkOutput("t3_d_stall", 32'(d_stall), 0);
      step();
      applyStimulus(0, 0, 1, 0, 8'h05, 0);
      dExpQ.push_back(16'hBEEF);
      @(negedge clk);
      checkOutput("t3_store_d_valid", 32'(d_valid), 1);
      checkOutput("t3_load_m_we", 32'(m_we), 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t3_load_d_valid", 32'(d_valid), 1);
      step();

      // Test 4: reset while an IF read is outstanding
      applyStimulus(1, 8'h10, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t4_grant_m_en", 32'(m_en), 1);
      step();
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t4_rst_i_valid", 32'(i_valid), 0);
      checkOutput("t4_rst_i_rdata", 32'(i_rdata), 0);
      checkOutput("t4_rst_m_en", 32'(m_en), 0);
      step();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("t4_post_i_valid", 32'(i_valid), 0);
      checkOutput("t4_post_i_rdata", 32'(i_rdata), 0);
      checkOutput("t4_post_d_rdata", 32'(d_rdata), 0);
      checkOutput("t4_post_conflict_cnt", 32'(conflict_cnt), 0);
      step();

      // Test 4b: after reset, IF wins the first conflict only in the round-robin build
      applyStimulus(1, 8'h30, 1, 0, 8'h20, 0);
      @(negedge clk);
`ifdef ROUND_ROBIN_EN
      checkOutput("t4b_i_stall", 32'(i_stall), 0);
      iExpQ.push_back(16'h3030);
`else
      checkOutput("t4b_i_stall", 32'(i_stall), 1);
      dExpQ.push_back(16'h2020);
`endif
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;

      // Test 6: conflict counter saturates and does not wrap
      monOn = 1'b0;
      applyStimulus(1, 8'h30, 1, 0, 8'h20, 0);
      for (int k = 1; k <= 65540; k++) begin
         if (k == 65535) begin
            @(negedge clk);
            checkOutput("t6_conflict_cnt_pre_sat", 32'(conflict_cnt), 32'hFFFE);
         end
         step();
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t6_conflict_cnt_sat", 32'(conflict_cnt), 32'hFFFF);
      step();
      step();
      @(negedge clk);
      checkOutput("t6_conflict_cnt_hold", 32'(conflict_cnt), 32'hFFFF);
      monOn = 1'b1;
      step();

      checkOutput("end_iExpQ_empty", 32'(iExpQ.size()), 0);
      checkOutput("end_dExpQ_empty", 32'(dExpQ.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
